// File: rtl/centroid_bbox.sv
// centroid_bbox
//   Collects the area (m00), first moments (m10, m01) and bounding box of a
//   binary mask over one video frame. Pixel coordinates are rebuilt from the
//   de/vsync timing, so any resolution up to 2**COORD_W per axis works. When
//   vsync rises (end of frame) the sums are copied out and the accumulators
//   are cleared. Two serial restoring dividers then run in parallel to form
//   the centroid.
//
// Ports
//   clk        pixel clock
//   rst_n      asynchronous active-low reset
//   de         pixel valid
//   vsync      frame sync, active high; its rising edge ends a frame
//   mask       object pixel, qualified by de
//   x, y       centroid of the last completed frame
//   x_min/x_max, y_min/y_max  bounding box of the last completed frame
//   area       m00 of the last completed frame
//   detected   area >= MIN_AREA
//   res_valid  one-cycle strobe: all result outputs updated this cycle
//   busy       dividers running
//   overrun    sticky: a frame ended while the dividers were still busy
module centroid_bbox #(
   parameter int COORD_W  = 11,
   parameter int AREA_W   = 22,
   parameter int SUM_W    = 33,
   parameter int MIN_AREA = 1,
   parameter int ROUND    = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               de,
   input  logic               vsync,
   input  logic               mask,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic [COORD_W-1:0] x_min,
   output logic [COORD_W-1:0] x_max,
   output logic [COORD_W-1:0] y_min,
   output logic [COORD_W-1:0] y_max,
   output logic [AREA_W-1:0]  area,
   output logic               detected,
   output logic               res_valid,
   output logic               busy,
   output logic               overrun
);

   localparam int                 CNT_W    = $clog2(SUM_W + 1);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SUM_W);
   localparam logic [COORD_W-1:0] C_MAX    = '1;

   function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
      return (v == C_MAX) ? v : v + COORD_W'(1);
   endfunction

   // Adding half the divisor turns the floor division into round-half-up.
   function automatic logic [SUM_W-1:0] rnd_dividend(input logic [SUM_W-1:0]  m,
                                                     input logic [AREA_W-1:0] d);
      if (ROUND != 0) return m + SUM_W'(d >> 1);
      return m;
   endfunction

   // One restoring step: shift the next dividend bit into the remainder and
   // subtract if it fits. The quotient bit enters the dividend shift register
   // from the right, so after SUM_W steps that register holds the quotient.
   function automatic logic [AREA_W+SUM_W-1:0] div_step(input logic [AREA_W-1:0] rem,
                                                        input logic [SUM_W-1:0]  q,
                                                        input logic [AREA_W-1:0] d);
      logic [AREA_W:0] rem_sh;
      rem_sh = {rem, q[SUM_W-1]};
      if (rem_sh >= {1'b0, d})
         return {AREA_W'(rem_sh - {1'b0, d}), q[SUM_W-2:0], 1'b1};
      return {rem_sh[AREA_W-1:0], q[SUM_W-2:0], 1'b0};
   endfunction

   logic               vsync_q, de_q, eof, hit;
   logic [COORD_W-1:0] x_pos, y_pos;
   logic [AREA_W-1:0]  m00_p0;
   logic [SUM_W-1:0]   m10_p0, m01_p0;
   logic [COORD_W-1:0] xmin_p0, xmax_p0, ymin_p0, ymax_p0;

   logic [AREA_W-1:0]  m00_p1, remx_p1, remy_p1;
   logic [SUM_W-1:0]   qx_p1, qy_p1;
   logic [COORD_W-1:0] xmin_p1, xmax_p1, ymin_p1, ymax_p1;
   logic [CNT_W-1:0]   cnt_p1;
   logic               vld_p1, det_p1;
   logic [AREA_W+SUM_W-1:0] stx_p1, sty_p1;

   assign eof    = vsync & ~vsync_q;
   assign hit    = de & mask & ~vsync;
   assign busy   = vld_p1;
   assign det_p1 = int'(m00_p1) >= MIN_AREA;
   assign stx_p1 = div_step(remx_p1, qx_p1, m00_p1);
   assign sty_p1 = div_step(remy_p1, qy_p1, m00_p1);

   // ---- p0: pixel position tracking and moment/bbox accumulation ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q <= 1'b0;
         de_q    <= 1'b0;
         x_pos   <= '0;
         y_pos   <= '0;
         m00_p0  <= '0;
         m10_p0  <= '0;
         m01_p0  <= '0;
         xmin_p0 <= '1;
         xmax_p0 <= '0;
         ymin_p0 <= '1;
         ymax_p0 <= '0;
      end else begin
         vsync_q <= vsync;
         de_q    <= de & ~vsync;   // de is ignored during vsync, so no line ends there
         if (vsync) begin
            x_pos <= '0;
            y_pos <= '0;
         end else if (de) begin
            x_pos <= sat_inc(x_pos);
         end else if (de_q) begin
            x_pos <= '0;
            y_pos <= sat_inc(y_pos);
         end
         if (eof) begin
            m00_p0  <= '0;
            m10_p0  <= '0;
            m01_p0  <= '0;
            xmin_p0 <= '1;
            xmax_p0 <= '0;
            ymin_p0 <= '1;
            ymax_p0 <= '0;
         end else if (hit) begin
            m00_p0 <= m00_p0 + AREA_W'(1);
            m10_p0 <= m10_p0 + SUM_W'(x_pos);
            m01_p0 <= m01_p0 + SUM_W'(y_pos);
            if (x_pos < xmin_p0) xmin_p0 <= x_pos;
            if (x_pos > xmax_p0) xmax_p0 <= x_pos;
            if (y_pos < ymin_p0) ymin_p0 <= y_pos;
            if (y_pos > ymax_p0) ymax_p0 <= y_pos;
         end
      end
   end

   // ---- p1: end-of-frame snapshot and serial division ----
   always_ff @(posedge clk) begin
      if (eof) begin
         m00_p1  <= m00_p0;
         xmin_p1 <= xmin_p0;
         xmax_p1 <= xmax_p0;
         ymin_p1 <= ymin_p0;
         ymax_p1 <= ymax_p0;
         qx_p1   <= rnd_dividend(m10_p0, m00_p0);
         qy_p1   <= rnd_dividend(m01_p0, m00_p0);
         remx_p1 <= '0;
         remy_p1 <= '0;
      end else if (vld_p1 && cnt_p1 != CNT_LAST) begin
         {remx_p1, qx_p1} <= stx_p1;
         {remy_p1, qy_p1} <= sty_p1;
      end
   end

   // ---- p2: division sequencing and registered results ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1    <= 1'b0;
         cnt_p1    <= '0;
         res_valid <= 1'b0;
         overrun   <= 1'b0;
         x         <= '0;
         y         <= '0;
         x_min     <= '0;
         x_max     <= '0;
         y_min     <= '0;
         y_max     <= '0;
         area      <= '0;
         detected  <= 1'b0;
      end else begin
         res_valid <= 1'b0;
         if (eof) begin
            // A new frame always wins; an unfinished division is discarded.
            if (vld_p1) overrun <= 1'b1;
            vld_p1 <= 1'b1;
            cnt_p1 <= '0;
         end else if (vld_p1) begin
            if (cnt_p1 == CNT_LAST) begin
               vld_p1    <= 1'b0;
               res_valid <= 1'b1;
               area      <= m00_p1;
               detected  <= det_p1;
               x         <= det_p1 ? qx_p1[COORD_W-1:0] : '0;
               y         <= det_p1 ? qy_p1[COORD_W-1:0] : '0;
               x_min     <= det_p1 ? xmin_p1 : '0;
               x_max     <= det_p1 ? xmax_p1 : '0;
               y_min     <= det_p1 ? ymin_p1 : '0;
               y_max     <= det_p1 ? ymax_p1 : '0;
            end else begin
               cnt_p1 <= cnt_p1 + CNT_W'(1);
            end
         end
      end
   end

endmodule
